// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the shared-ALU arbiter: op codes and NZCV flag bit positions.
package alu_share_arbiter_pkg;

    // 4-bit ALU op codes
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_ORR  = 4'h3;
    localparam logic [3:0] OP_EXOR = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLL  = 4'h6;
    localparam logic [3:0] OP_SRL  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_MOVE = 4'h9;
    localparam logic [3:0] OP_SLTU = 4'hA;

    // Bit positions inside the 4-bit NZCV flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int NUM_REQ = 2;

endpackage

// File: rtl/alu.sv
// Combinational ALU with NZCV flags. C/V are only meaningful for ADD/SUB (C = no-borrow on SUB);
// unknown op codes give a zero result, so Z reads set.
module alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       ctrl,
    input  logic             ci,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic             carry;
    logic             ovf;
    logic [SHW-1:0]   shamt;

    assign shamt = b[SHW-1:0];

    // Operation decode, result and flag generation
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        out   = '0;
        case (ctrl)
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
                out   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                out   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (out[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  out = a & b;
            OP_ORR:  out = a | b;
            OP_EXOR: out = a ^ b;
            OP_SLT:  out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  out = a << shamt;
            OP_SRL:  out = a >> shamt;
            OP_SRA:  out = $signed(a) >>> shamt;
            OP_MOVE: out = b;
            OP_SLTU: out = {{(WIDTH-1){1'b0}}, (a < b)};
            default: out = '0;
        endcase
        flags         = 4'b0000;
        flags[FLAG_N] = out[WIDTH-1];
        flags[FLAG_Z] = (out == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant. While locked, only the lock owner may be granted.
module alu_share_arbiter_rr_arb2
    import alu_share_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               prio,
    input  logic               locked,
    input  logic               lock_owner,
    output logic [NUM_REQ-1:0] grant
);

    // Lock mask first, then single-requester win, then priority tie-break
    always_comb begin
        grant = '0;
        if (locked) begin
            grant[lock_owner] = valid[lock_owner];
        end else if (valid == 2'b11) begin
            grant[prio] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two requesters; result and flags land in a 1-deep response register.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_ctrl,
    input  logic             req0_ci,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_lock,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_ctrl,
    input  logic             req1_ci,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_lock,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags
);

    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] req_hs;
    logic [NUM_REQ-1:0] grant;
    logic               accept;
    logic               hs;
    logic               sel;
    logic               sel_lock;

    logic [3:0]         alu_ctrl;
    logic               alu_ci;
    logic [WIDTH-1:0]   alu_a;
    logic [WIDTH-1:0]   alu_b;
    logic [WIDTH-1:0]   alu_out;
    logic [3:0]         alu_flags;

    logic               rsp_valid_reg;
    logic               rsp_id_reg;
    logic [WIDTH-1:0]   rsp_data_reg;
    logic [3:0]         rsp_flags_reg;
    logic               prio_reg;
    logic               locked_reg;
    logic               lock_owner_reg;

    assign req_valid = {req1_valid, req0_valid};
    // The register can take a new result when empty or being drained this cycle
    assign accept    = !rsp_valid_reg || rsp_ready;

    alu_share_arbiter_rr_arb2 u_arb (
        .valid      (req_valid),
        .prio       (prio_reg),
        .locked     (locked_reg),
        .lock_owner (lock_owner_reg),
        .grant      (grant)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_ready[gi] = accept && grant[gi];
        assign req_hs[gi]    = req_valid[gi] && req_ready[gi];
    end

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];
    assign hs         = |req_hs;
    assign sel        = req_hs[1];

    // Operand mux: grant is one-hot, so a handshake by req1 selects req1, otherwise req0
    always_comb begin
        alu_ctrl = sel ? req1_ctrl : req0_ctrl;
        alu_ci   = sel ? req1_ci   : req0_ci;
        alu_a    = sel ? req1_a    : req0_a;
        alu_b    = sel ? req1_b    : req0_b;
        sel_lock = sel ? req1_lock : req0_lock;
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .ctrl  (alu_ctrl),
        .ci    (alu_ci),
        .a     (alu_a),
        .b     (alu_b),
        .out   (alu_out),
        .flags (alu_flags)
    );

    // Response register, round-robin pointer and lock state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg  <= 1'b0;
            rsp_id_reg     <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_flags_reg  <= '0;
            prio_reg       <= 1'b0;
            locked_reg     <= 1'b0;
            lock_owner_reg <= 1'b0;
        end else begin
            if (hs) begin
                rsp_valid_reg <= 1'b1;
                rsp_id_reg    <= sel;
                rsp_data_reg  <= alu_out;
                rsp_flags_reg <= alu_flags;
                prio_reg      <= ~sel;
                if (sel_lock) begin
                    locked_reg     <= 1'b1;
                    lock_owner_reg <= sel;
                end else if (locked_reg && (lock_owner_reg == sel)) begin
                    locked_reg     <= 1'b0;
                end
            end else if (rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_flags = rsp_flags_reg;

endmodule
